// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the MEM-stage access unit: FSM encoding,
// alignment mask and the doubleword alignment helper.
package mem_access_unit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mau_state_e;

  localparam logic [2:0] DW_ALIGN_MASK = 3'b111;
  localparam int         WAIT_CNT_W    = 8;

  function automatic logic is_dw_aligned(input logic [63:0] addr);
    return (addr[2:0] & DW_ALIGN_MASK) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_unit_wb.sv
// MEM/WB pipeline register bank. A bubble clears only the valid and
// register-write bits; the data fields keep their last value.
module mem_wb_reg
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        bubble,
  input  logic        valid,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [63:0] read_data,
  input  logic [63:0] ALU_result,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [63:0] read_data_out,
  output logic [63:0] ALU_result_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out      <= 1'b0;
      rd_out         <= '0;
      RegWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      read_data_out  <= '0;
      ALU_result_out <= '0;
    end else if (bubble) begin
      valid_out    <= 1'b0;
      RegWrite_out <= 1'b0;
    end else if (load_en) begin
      valid_out      <= valid;
      rd_out         <= rd;
      RegWrite_out   <= RegWrite;
      MemtoReg_out   <= MemtoReg;
      read_data_out  <= read_data;
      ALU_result_out <= ALU_result;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues one doubleword load/store at a time, stalls
// the pipeline until the memory acknowledges, and times out stuck requests.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [4:0]  rd,
  input  logic [63:0] ALU_result,
  input  logic [63:0] write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        stall,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [63:0] read_data_out,
  output logic [63:0] ALU_result_out,
  output logic        access_err
);

  // Handshake: mem_req rises with the request; mem_addr/mem_we/mem_wdata stay
  // constant while mem_req is high until the single-cycle mem_ack, and
  // mem_rdata is sampled only on that ack cycle. Acks outside WAIT are ignored.

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYC - 1);

  mau_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [63:0]           lat_addr_q;
  logic [63:0]           lat_wdata_q;
  logic                  lat_we_q;
  logic [4:0]            lat_rd_q;
  logic                  lat_regwrite_q;
  logic                  lat_memtoreg_q;
  logic                  access_err_q;

  logic        memop;
  logic        aligned;
  logic        issue;
  logic        misalign;
  logic        complete;
  logic        timeout;
  logic        pass_through;

  logic        wb_load_en;
  logic        wb_bubble;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        wb_memtoreg;
  logic [63:0] wb_read_data;
  logic [63:0] wb_alu_result;

  assign memop   = valid_in & (MemRead | MemWrite);
  assign aligned = is_dw_aligned(ALU_result);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = ~MemRead;
    mem_addr     = ALU_result;
    mem_wdata    = write_data;
    stall        = 1'b0;
    issue        = 1'b0;
    misalign     = 1'b0;
    complete     = 1'b0;
    timeout      = 1'b0;
    pass_through = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memop) begin
          if (aligned) begin
            mem_req = 1'b1;
            stall   = 1'b1;
            issue   = 1'b1;
            state_d = ST_WAIT;
          end else begin
            misalign = 1'b1;
          end
        end else begin
          pass_through = 1'b1;
        end
      end
      ST_WAIT: begin
        mem_req   = 1'b1;
        mem_we    = lat_we_q;
        mem_addr  = lat_addr_q;
        mem_wdata = lat_wdata_q;
        stall     = ~mem_ack;
        // A completion on the last allowed cycle beats the timeout.
        if (mem_ack) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!reset) begin
      mem_req = 1'b0;
      stall   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q     <= '0;
      lat_addr_q     <= '0;
      lat_wdata_q    <= '0;
      lat_we_q       <= 1'b0;
      lat_rd_q       <= '0;
      lat_regwrite_q <= 1'b0;
      lat_memtoreg_q <= 1'b0;
    end else if (issue) begin
      wait_cnt_q     <= '0;
      lat_addr_q     <= ALU_result;
      lat_wdata_q    <= write_data;
      lat_we_q       <= ~MemRead;
      lat_rd_q       <= rd;
      lat_regwrite_q <= RegWrite;
      lat_memtoreg_q <= MemtoReg;
    end else if (state_q == ST_WAIT && !mem_ack) begin
      wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      access_err_q <= 1'b0;
    end else if (misalign || timeout) begin
      access_err_q <= 1'b1;
    end
  end

  assign access_err = access_err_q;

  // Every cycle that neither passes an instruction through nor retires a
  // memory access writes a bubble into MEM/WB.
  assign wb_load_en    = pass_through | complete;
  assign wb_bubble     = ~wb_load_en;
  assign wb_valid      = complete ? 1'b1 : valid_in;
  assign wb_rd         = complete ? lat_rd_q : rd;
  assign wb_regwrite   = complete ? lat_regwrite_q : RegWrite;
  assign wb_memtoreg   = complete ? lat_memtoreg_q : MemtoReg;
  assign wb_read_data  = (complete && !lat_we_q) ? mem_rdata : 64'd0;
  assign wb_alu_result = complete ? lat_addr_q : ALU_result;

  mem_wb_reg u_mem_wb_reg (
    .clk            (clk),
    .reset          (reset),
    .load_en        (wb_load_en),
    .bubble         (wb_bubble),
    .valid          (wb_valid),
    .rd             (wb_rd),
    .RegWrite       (wb_regwrite),
    .MemtoReg       (wb_memtoreg),
    .read_data      (wb_read_data),
    .ALU_result     (wb_alu_result),
    .valid_out      (valid_out),
    .rd_out         (rd_out),
    .RegWrite_out   (RegWrite_out),
    .MemtoReg_out   (MemtoReg_out),
    .read_data_out  (read_data_out),
    .ALU_result_out (ALU_result_out)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// instruction streams compared against a transaction-level reference model.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam int SW = 137;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [4:0]  rd;
  logic [63:0] ALU_result;
  logic [63:0] write_data;
  logic        MemRead, MemWrite, RegWrite, MemtoReg;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out, MemtoReg_out;
  logic [63:0] read_data_out, ALU_result_out;
  logic        access_err;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .rd(rd),
    .ALU_result(ALU_result), .write_data(write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .valid_out(valid_out), .rd_out(rd_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .read_data_out(read_data_out),
    .ALU_result_out(ALU_result_out), .access_err(access_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // reference model: one outstanding request plus expected MEM/WB slots
  bit          m_busy;
  int          m_waited;
  logic [63:0] m_addr, m_wdata;
  bit          m_load;
  logic [4:0]  m_rd;
  bit          m_rw, m_m2r;
  bit          e_err;
  bit          e_req, e_stall, e_we;
  logic [63:0] e_maddr, e_mwdata;
  logic [SW-1:0] exp_q[$];

  // observation counters for directed literal checks
  int          n_req, n_stall;
  logic [63:0] last_addr, last_wdata;
  logic        last_we;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] pack(input bit full, input logic v, input logic [4:0] r,
                                         input logic rw, input logic m2r,
                                         input logic [63:0] rdat, input logic [63:0] alu);
    return {full, v, r, rw, m2r, rdat, alu};
  endfunction

  function automatic bit in_memop();
    return valid_in && (MemRead || MemWrite);
  endfunction

  task automatic model_reset();
    m_busy   = 0;
    m_waited = 0;
    e_err    = 0;
    exp_q.delete();
  endtask

  task automatic model_comb();
    if (!m_busy) begin
      e_req    = in_memop() && (ALU_result % 8 == 0);
      e_stall  = e_req;
      e_maddr  = ALU_result;
      e_mwdata = write_data;
      e_we     = !MemRead;
    end else begin
      e_req    = 1;
      e_stall  = !mem_ack;
      e_maddr  = m_addr;
      e_mwdata = m_wdata;
      e_we     = !m_load;
    end
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (in_memop() && (ALU_result % 8 != 0)) begin
        e_err = 1;
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      end else if (in_memop()) begin
        m_busy = 1; m_waited = 0;
        m_addr = ALU_result; m_wdata = write_data; m_load = MemRead;
        m_rd = rd; m_rw = RegWrite; m_m2r = MemtoReg;
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
      end else begin
        exp_q.push_back(pack(1, valid_in, rd, RegWrite, MemtoReg, 64'd0, ALU_result));
      end
    end else if (mem_ack) begin
      exp_q.push_back(pack(1, 1, m_rd, m_rw, m_m2r, m_load ? mem_rdata : 64'd0, m_addr));
      m_busy = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        e_err  = 1;
        m_busy = 0;
      end
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic check_regs();
    logic [SW-1:0] s;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL exp_q: no expected MEM/WB slot queued");
      return;
    end
    s = exp_q.pop_front();
    check("valid_out", valid_out, s[135]);
    check("RegWrite_out", RegWrite_out, s[129]);
    if (s[136]) begin
      check("rd_out", rd_out, s[134:130]);
      check("MemtoReg_out", MemtoReg_out, s[128]);
      check("read_data_out", read_data_out, s[127:64]);
      check("ALU_result_out", ALU_result_out, s[63:0]);
    end
    check("access_err", access_err, e_err);
  endtask

  // one clock cycle: called just after a falling edge with inputs set
  task automatic tick();
    #1;
    model_comb();
    check("mem_req", mem_req, e_req);
    check("stall", stall, e_stall);
    if (e_req) begin
      check("mem_addr", mem_addr, e_maddr);
      check("mem_we", mem_we, e_we);
      check("mem_wdata", mem_wdata, e_mwdata);
    end
    if (mem_req) begin
      n_req++; last_addr = mem_addr; last_we = mem_we; last_wdata = mem_wdata;
    end
    if (stall) n_stall++;
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic [4:0] r, input logic [63:0] alu,
                           input logic [63:0] wd, input logic mr, input logic mw,
                           input logic rw, input logic m2r);
    valid_in = v; rd = r; ALU_result = alu; write_data = wd;
    MemRead = mr; MemWrite = mw; RegWrite = rw; MemtoReg = m2r;
  endtask

  // issue the current instruction, hold it while stalled, ack on WAIT cycle ack_at (0 = never)
  task automatic run_op(input int ack_at, input logic [63:0] rdat, input bit spur);
    int guard;
    guard = 0;
    n_req = 0; n_stall = 0;
    mem_ack = spur;
    mem_rdata = {$urandom(), $urandom()};
    tick();
    mem_ack = 0;
    while (m_busy) begin
      mem_ack   = (m_waited + 1 == ack_at);
      mem_rdata = mem_ack ? rdat : {$urandom(), $urandom()};
      tick();
      mem_ack = 0;
      guard++;
      if (guard > 20 && m_busy) begin
        checks++; errors++;
        $display("FAIL wait_bound: request still outstanding after %0d cycles", guard);
        m_busy = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int kind, ack_at;
    logic [63:0] addr;
    logic mr, mw;

    // reset state, with a live aligned load presented during reset
    reset = 0; mem_ack = 0; mem_rdata = '0;
    set_instr(1, 5'd1, 64'h40, 64'h0, 1, 0, 1, 1);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_ALU_result_out", ALU_result_out, 0);
    check("rst_access_err", access_err, 0);
    @(negedge clk);
    reset = 1;

    // ALU op passes through in one cycle
    set_instr(1, 5'd5, 64'h2A, 64'h0, 0, 0, 1, 0);
    run_op(0, 0, 0);
    check("alu_rd_out", rd_out, 5);
    check("alu_result_out", ALU_result_out, 64'h2A);
    check("alu_valid_out", valid_out, 1);
    check("alu_stall_cycles", n_stall, 0);

    // load from 0x100, ack on the third cycle after issue
    set_instr(1, 5'd7, 64'h100, 64'h1111, 1, 0, 1, 1);
    run_op(3, 64'hDEADBEEF, 0);
    check("ld_stall_cycles", n_stall, 3);
    check("ld_addr", last_addr, 64'h100);
    check("ld_read_data_out", read_data_out, 64'hDEADBEEF);
    check("ld_MemtoReg_out", MemtoReg_out, 1);
    check("ld_valid_out", valid_out, 1);

    // store 0x55 to 0x08, ack after one cycle
    set_instr(1, 5'd9, 64'h08, 64'h55, 0, 1, 0, 0);
    run_op(1, 64'hFFFF_0000_FFFF_0000, 0);
    check("st_mem_we", last_we, 1);
    check("st_mem_wdata", last_wdata, 64'h55);
    check("st_valid_out", valid_out, 1);
    check("st_read_data_out", read_data_out, 0);

    // reset during WAIT abandons the access
    set_instr(1, 5'd12, 64'h200, 64'h0, 1, 0, 1, 1);
    mem_ack = 0;
    tick();
    tick();
    reset = 0;
    #2;
    model_reset();
    check("rw_mem_req", mem_req, 0);
    check("rw_stall", stall, 0);
    check("rw_valid_out", valid_out, 0);
    check("rw_rd_out", rd_out, 0);
    check("rw_RegWrite_out", RegWrite_out, 0);
    check("rw_MemtoReg_out", MemtoReg_out, 0);
    check("rw_read_data_out", read_data_out, 0);
    check("rw_ALU_result_out", ALU_result_out, 0);
    check("rw_access_err", access_err, 0);
    @(negedge clk);
    reset = 1;
    set_instr(1, 5'd3, 64'h77, 64'h0, 0, 0, 1, 0);
    run_op(0, 0, 0);
    check("rw_alu_rd_out", rd_out, 3);
    check("rw_alu_result_out", ALU_result_out, 64'h77);
    check("rw_alu_valid_out", valid_out, 1);

    // ack arriving on the last allowed WAIT cycle completes without error
    set_instr(1, 5'd4, 64'h300, 64'h0, 1, 0, 1, 1);
    run_op(TO, 64'h1234, 0);
    check("to_ack_err", access_err, 0);
    check("to_ack_valid_out", valid_out, 1);
    check("to_ack_read_data_out", read_data_out, 64'h1234);

    // no ack: request dropped after TO WAIT cycles
    set_instr(1, 5'd6, 64'h308, 64'h0, 1, 0, 1, 1);
    run_op(0, 0, 0);
    check("to_req_cycles", n_req, TO + 1);
    set_instr(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 0);
    #1;
    check("to_mem_req", mem_req, 0);
    check("to_stall", stall, 0);
    check("to_access_err", access_err, 1);
    check("to_valid_out", valid_out, 0);
    @(negedge clk);

    // misaligned load
    do_reset();
    set_instr(1, 5'd2, 64'h103, 64'h0, 1, 0, 1, 1);
    run_op(0, 0, 0);
    check("mis_req_cycles", n_req, 0);
    check("mis_access_err", access_err, 1);
    check("mis_valid_out", valid_out, 0);

    // randomized instruction stream
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 75 == 74) do_reset();
      kind = $urandom_range(0, 9);
      addr = {$urandom(), $urandom()};
      addr[2:0] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      case (kind)
        0, 1, 2: begin mr = 0; mw = 0; end
        3, 4, 5: begin mr = 1; mw = 0; end
        6, 7:    begin mr = 0; mw = 1; end
        8:       begin mr = 1; mw = 1; end
        default: begin mr = 1'($urandom_range(0, 1)); mw = 1'($urandom_range(0, 1)); end
      endcase
      set_instr(kind != 9, 5'($urandom_range(0, 31)), addr, {$urandom(), $urandom()},
                mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ack_at = $urandom_range(1, TO + 1);
      run_op(ack_at, {$urandom(), $urandom()}, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
